// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks.
//   coll_state_e : activation collector state encoding
//   acc_width()  : accumulator width used by both the MAC engine and the
//                  collector, 2*data_w plus the growth of summing n_in products
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } coll_state_e;

    function automatic int acc_width(input int data_w, input int n_in);
        return 2 * data_w + $clog2((n_in > 2) ? n_in : 2);
    endfunction

endpackage

// File: rtl/act_quant.sv
// Combinational requantiser: optional ReLU, round-half-up arithmetic right
// shift by FRAC_SHIFT, then saturation to a signed DATA_W result.
//   acc_i : signed ACC_W accumulator value
//   act_o : signed DATA_W activation
//   sat_o : 1 when act_o was clamped to the DATA_W range
module act_quant
    import nn_pkg::*;
#(
    parameter  int DATA_W     = 16,
    parameter  int N_IN       = 128,
    parameter  int FRAC_SHIFT = 8,
    parameter  int RELU_EN    = 1,
    localparam int ACC_W      = acc_width(DATA_W, N_IN)
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [DATA_W-1:0] act_o,
    output logic                     sat_o
);

    localparam logic signed [ACC_W:0] ONE   = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] MAX_V = (ONE <<< (DATA_W - 1)) - ONE;
    localparam logic signed [ACC_W:0] MIN_V = -(ONE <<< (DATA_W - 1));

    logic signed [ACC_W:0] relu_s;
    logic signed [ACC_W:0] shifted_s;

    // Rectify and widen by one bit so the rounding add can never overflow
    always_comb begin
        if ((RELU_EN != 0) && acc_i[ACC_W-1]) begin
            relu_s = '0;
        end else begin
            relu_s = {acc_i[ACC_W-1], acc_i};
        end
    end

    generate
        if (FRAC_SHIFT > 0) begin : g_round
            localparam logic signed [ACC_W:0] HALF = ONE <<< (FRAC_SHIFT - 1);
            assign shifted_s = (relu_s + HALF) >>> FRAC_SHIFT;
        end else begin : g_no_round
            assign shifted_s = relu_s;
        end
    endgenerate

    // Clamp to the signed DATA_W range and flag any clamp
    always_comb begin
        if (shifted_s > MAX_V) begin
            act_o = MAX_V[DATA_W-1:0];
            sat_o = 1'b1;
        end else if (shifted_s < MIN_V) begin
            act_o = MIN_V[DATA_W-1:0];
            sat_o = 1'b1;
        end else begin
            act_o = shifted_s[DATA_W-1:0];
            sat_o = 1'b0;
        end
    end

endmodule

// File: rtl/act_collector.sv
// Collects N_HIDDEN requantised accumulator beats into a packed activation
// vector and holds it until the consumer acknowledges.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : arm collection of one layer (IDLE, or HOLD with vec_ack)
//   in_data/in_valid  : accumulator beat, accepted when in_valid && in_ready
//   in_ready          : high while collecting
//   vec_bus/vec_valid : packed activations, lane i at [i*DATA_W +: DATA_W]
//   vec_ack           : consumer has taken vec_bus
//   busy              : not idle
//   sat_flag          : sticky, some beat of the current layer saturated
module act_collector
    import nn_pkg::*;
#(
    parameter  int DATA_W     = 16,
    parameter  int N_IN       = 128,
    parameter  int N_HIDDEN   = 64,
    parameter  int FRAC_SHIFT = 8,
    parameter  int RELU_EN    = 1,
    localparam int ACC_W      = acc_width(DATA_W, N_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [ACC_W-1:0]  in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N_IN*DATA_W-1:0]   vec_bus,
    output logic                     vec_valid,
    input  logic                     vec_ack,
    output logic                     busy,
    output logic                     sat_flag
);

    localparam int CNT_W = $clog2(N_HIDDEN) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_HIDDEN - 1);

    generate
        if (N_HIDDEN > N_IN) begin : g_bad_hidden
            $error("act_collector: N_HIDDEN must not exceed N_IN");
        end
        if ((FRAC_SHIFT < 0) || (FRAC_SHIFT > DATA_W)) begin : g_bad_shift
            $error("act_collector: FRAC_SHIFT must lie in 0..DATA_W");
        end
    endgenerate

    coll_state_e               state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [N_IN*DATA_W-1:0]    vec_q, vec_d;
    logic                      sat_q, sat_d;
    logic                      in_ready_q, in_ready_d;
    logic                      vec_valid_q, vec_valid_d;
    logic                      busy_q, busy_d;

    logic signed [DATA_W-1:0]  q_act_s;
    logic                      q_sat_s;
    logic                      beat_fire_s;

    act_quant #(
        .DATA_W     (DATA_W),
        .N_IN       (N_IN),
        .FRAC_SHIFT (FRAC_SHIFT),
        .RELU_EN    (RELU_EN)
    ) u_quant (
        .acc_i (in_data),
        .act_o (q_act_s),
        .sat_o (q_sat_s)
    );

    // in_ready_q mirrors state == COLLECT, so it doubles as the accept qualifier
    assign beat_fire_s = in_valid && in_ready_q;

    // Next-state, lane write and sticky saturation logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        vec_d   = vec_q;
        sat_d   = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                    count_d = '0;
                    vec_d   = '0;
                    sat_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (beat_fire_s) begin
                    // count_q < N_HIDDEN here, so upper lanes are never written
                    vec_d[int'(count_q)*DATA_W +: DATA_W] = q_act_s;
                    sat_d   = sat_q | q_sat_s;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_BEAT) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (vec_ack && start) begin
                    state_d = ST_COLLECT;
                    count_d = '0;
                    vec_d   = '0;
                    sat_d   = 1'b0;
                end else if (vec_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_COLLECT);
        vec_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            vec_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            vec_q       <= vec_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            vec_valid_q <= vec_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign vec_bus   = vec_q;
    assign vec_valid = vec_valid_q;
    assign busy      = busy_q;
    assign sat_flag  = sat_q;

endmodule
